// File: rtl/col_expand512.sv
// Count-to-column expander: turns a population count into a thermometer-coded column.
// Optional feature: define COL_EXPAND_ROTATE_EN to rotate each emitted column by a running offset.
module col_expand512 #(
  parameter int COL_W = 512,
  parameter int CNT_W = 10
`ifdef COL_EXPAND_ROTATE_EN
  ,
  parameter int ROT_STEP = 1
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [COL_W-1:0] out_col,
  output logic             out_sat,
  output logic [15:0]      sat_cnt
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high.
  // A producer holds valid and its data until that edge; ready never waits on valid.

  localparam logic [CNT_W-1:0] COL_W_C = CNT_W'(COL_W);

  logic             s1_valid;
  logic [CNT_W-1:0] s1_cnt;
  logic             s1_sat;
  logic             adv1;
  logic             adv2;
  logic             in_fire;
  logic             in_over;
  logic [COL_W-1:0] therm;
  logic [COL_W-1:0] col_next;

  assign adv2     = !out_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = adv1;
  assign in_fire  = in_valid && adv1;
  assign in_over  = in_cnt > COL_W_C;

  // A shift by COL_W leaves zero, so the inversion yields all ones for a full count.
  assign therm = ~({COL_W{1'b1}} << s1_cnt);

`ifdef COL_EXPAND_ROTATE_EN
  localparam int ROT_W = $clog2(COL_W);

  logic [ROT_W-1:0] rot;
  logic [ROT_W-1:0] rot_next;

  always_comb begin
    col_next = (therm << rot) | (therm >> (COL_W - int'(rot)));
    rot_next = ROT_W'((int'(rot) + ROT_STEP) % COL_W);
  end

  // Offset advances only when a real column lands in the output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rot <= '0;
    end else if (adv2 && s1_valid) begin
      rot <= rot_next;
    end
  end
`else
  assign col_next = therm;
`endif

  // Stage 1: clamp register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cnt   <= '0;
      s1_sat   <= 1'b0;
    end else if (adv1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cnt <= in_over ? COL_W_C : in_cnt;
        s1_sat <= in_over;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (in_fire && in_over && (sat_cnt != 16'hFFFF)) begin
      sat_cnt <= sat_cnt + 16'd1;
    end
  end

  // Stage 2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_col   <= '0;
      out_sat   <= 1'b0;
    end else if (adv2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_col <= col_next;
        out_sat <= s1_sat;
      end
    end
  end

endmodule

// File: tb/tb_col_expand512.sv
// Directed bench for col_expand512: expected columns come from a bit-loop thermometer model
// driven by a queue of accepted counts.
module tb_col_expand512;

  localparam int COL_W = 512;
  localparam int CNT_W = 10;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [CNT_W-1:0] in_cnt;
  logic             out_valid;
  logic             out_ready;
  logic [COL_W-1:0] out_col;
  logic             out_sat;
  logic [15:0]      sat_cnt;

  col_expand512 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_cnt    (in_cnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_col   (out_col),
    .out_sat   (out_sat),
    .sat_cnt   (sat_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int               n_checks;
  int               n_errors;
  logic [CNT_W-1:0] exp_q[$];
  int               emit_k;
  int               exp_sat;
  bit               rnd_rdy;
  logic [CNT_W-1:0] mon_cnt;

  task automatic check(input string tag, input logic [COL_W-1:0] got, input logic [COL_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int clamp_cnt(input logic [CNT_W-1:0] c);
    return (int'(c) > COL_W) ? COL_W : int'(c);
  endfunction

  function automatic logic [COL_W-1:0] model_col(input logic [CNT_W-1:0] c, input int k);
    logic [COL_W-1:0] t;
    logic [COL_W-1:0] r;
    int               n;
    int               rot;
    n = clamp_cnt(c);
    t = '0;
    for (int i = 0; i < n; i++) t[i] = 1'b1;
`ifdef COL_EXPAND_ROTATE_EN
    rot = k % COL_W;
`else
    rot = 0;
`endif
    r = '0;
    for (int i = 0; i < COL_W; i++) r[(i + rot) % COL_W] = t[i];
    return r;
  endfunction

  // scoreboard: every output transfer is matched against the oldest accepted count
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_col", COL_W'(1), COL_W'(0));
      end else begin
        mon_cnt = exp_q.pop_front();
        check("out_col", out_col, model_col(mon_cnt, emit_k));
        check("out_sat", COL_W'(out_sat), COL_W'(int'(mon_cnt) > COL_W));
        check("popcount", COL_W'($countones(out_col)), COL_W'(clamp_cnt(mon_cnt)));
        emit_k++;
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  // driver tasks
  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_cnt   = '0;
    exp_q.delete();
    emit_k  = 0;
    exp_sat = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CNT_W-1:0] c);
    in_valid = 1'b1;
    in_cnt   = c;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(c);
        if (int'(c) > COL_W) exp_sat++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", COL_W'(0), COL_W'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 2000; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    check("drain_left", COL_W'(exp_q.size()), COL_W'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rnd_rdy   = 1'b0;
    out_ready = 1'b0;
    do_reset();

    check("rst_out_valid", COL_W'(out_valid), COL_W'(0));
    check("rst_out_col", out_col, '0);
    check("rst_out_sat", COL_W'(out_sat), COL_W'(0));
    check("rst_sat_cnt", COL_W'(sat_cnt), COL_W'(0));
    check("rst_in_ready", COL_W'(in_ready), COL_W'(1));

    // boundary counts back-to-back
    out_ready = 1'b1;
    send(10'd0);
    send(10'd1);
    send(10'd511);
    send(10'd512);
    drain();
    check("sat_cnt_none", COL_W'(sat_cnt), COL_W'(0));

    // clamping
    send(10'd600);
    send(10'd1023);
    drain();
    check("sat_cnt_two", COL_W'(sat_cnt), COL_W'(2));

    // backpressure: two accepted, third blocked, head held
    out_ready = 1'b0;
    send(10'd5);
    send(10'd6);
    in_valid = 1'b1;
    in_cnt   = 10'd7;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", COL_W'(in_ready), COL_W'(0));
      check("stall_out_valid", COL_W'(out_valid), COL_W'(1));
      check("stall_out_col", out_col, model_col(10'd5, emit_k));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(10'd7);
    drain();

    // random counts with random downstream stalls
    rnd_rdy = 1'b1;
    for (int i = 0; i < 200; i++) send(10'($urandom_range(0, 1023)));
    rnd_rdy = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();
    check("sat_cnt_rand", COL_W'(sat_cnt), COL_W'(16'(exp_sat)));

    // reset during a stall with two counts buffered
    out_ready = 1'b0;
    send(10'd10);
    send(10'd20);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", COL_W'(out_valid), COL_W'(0));
    check("mid_rst_out_col", out_col, '0);
    check("mid_rst_sat_cnt", COL_W'(sat_cnt), COL_W'(0));
    exp_q.delete();
    emit_k  = 0;
    exp_sat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(10'd3);
    check("lat_n1_out_valid", COL_W'(out_valid), COL_W'(0));
    @(posedge clk);
    #1;
    check("lat_n2_out_valid", COL_W'(out_valid), COL_W'(1));
    check("lat_n2_out_col", out_col, model_col(10'd3, 0));
    drain();

    // single-bit and full columns from a fresh reset (rotation offsets start at zero)
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(10'd1);
    for (int i = 0; i < 3; i++) send(10'd512);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
